uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Serialises parallel bytes onto a UART line: 8N1 by default, optional parity and 2 stop bits.
//  Pairs with uart_rx on the same bit-timing scheme; baud_div clock cycles per bit, LSB first.
//  A small input FIFO absorbs bursts from the image-processing datapath, so bytes go out back-to-back.
// PARAMETERS
//  DATA_WIDTH   8  data bits per frame; also sizes the baud divider input (DATA_WIDTH*2+1 bits)
//  FIFO_DEPTH   4  input FIFO entries; power of two, >=2
//  PARITY_EN    0  1 = insert parity bit after the data bits
//  PARITY_ODD   0  1 = odd parity, 0 = even (ignored if PARITY_EN=0)
//  STOP_BITS    1  1 or 2 stop-bit periods
// PORTS
//  clk_i_tx          in   1               clock, single domain
//  rsnt_i_tx         in   1               asynchronous reset, active-high
//  baud_div_i_tx     in   DATA_WIDTH*2+1  clock cycles per bit; 0 is treated as 1
//  data_i_tx         in   DATA_WIDTH      byte to send
//  valid_i_tx        in   1               data_i_tx valid
//  ready_o_tx        out  1               FIFO not full; push occurs when valid_i_tx & ready_o_tx
//  data_o_serial_tx  out  1               serial line, registered, idles high
//  active_o_tx       out  1               high while a frame is on the line
//  done_o_tx         out  1               1-cycle pulse at the end of each frame's last stop period
// BEHAVIOUR
//  Reset values
//   - data_o_serial_tx=1, active_o_tx=0, done_o_tx=0.
//   - FIFO flushed (ready_o_tx=1); FSM returns to IDLE; all counters cleared.
//   - Reset mid-frame aborts the frame: the line goes high immediately.
//  ready_o_tx = !full, decoded combinationally from the occupancy count. A push while full cannot occur.
//  Push and pop in the same cycle leaves the count unchanged.
//  FSM states: IDLE, START, DATA, PARITY, STOP
//   - IDLE: line high, active low. If the FIFO is non-empty: pop the head into shift_reg,
//     latch baud_div (0 becomes 1) into div_q, drive the line 0, set active, go to START.
//   - START: hold 0 for div_q cycles, then drive bit0 and go to DATA.
//   - DATA: each bit is held div_q cycles, LSB first, via a right shift.
//     After bit DATA_WIDTH-1, go to PARITY if PARITY_EN, else STOP.
//   - PARITY: drive ^data (XOR with PARITY_ODD) for div_q cycles, then go to STOP.
//   - STOP: drive 1 for STOP_BITS*div_q cycles. At the final cycle:
//     * pulse done_o_tx;
//     * if the FIFO is non-empty, pop and go straight to START (no idle cycle between frames);
//     * otherwise drop active_o_tx and go to IDLE.
//  Latency: byte pushed at edge N, FIFO non-empty after N; popped at edge N+1, line low from edge N+1.
//  Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * div_q cycles, exact, with no jitter.
//  Parity is computed from the byte captured at pop time.
//  baud_div_i_tx changes mid-frame are ignored; the new value applies from the next pop.
//  Counters:
//   - baud counter has width DATA_WIDTH*2+1, counts 0..div_q-1 and wraps to 0 at each bit boundary;
//   - bit counter has width clog2(DATA_WIDTH)+1;
//   - stop counter counts STOP_BITS periods.
//  FIFO pointers have width clog2(FIFO_DEPTH) and wrap naturally; the count has width clog2(FIFO_DEPTH)+1.
// STRUCTURE
//  Shared package uart_pkg:
//   - state encoding localparams (IDLE/START/DATA/PARITY/STOP) shared with uart_rx;
//   - a parity-compute function.
//  Sub-module uart_tx_fifo (sync FIFO: push/pop/full/empty/count) instantiated once.
//  The top level holds the FSM, baud/bit counters and output registers.
// TESTING
//  1. baud_div=16, push 0xA5 once -> line low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each,
//     high 16 cycles; done pulse at cycle 160; active high exactly 160 cycles.
//  2. FIFO_DEPTH=4, baud_div=4, push 0x01..0x05 on consecutive cycles ->
//     ready drops after the 4th push is held off, the 5th is accepted once the first pop frees a slot;
//     5 frames contiguous (200 cycles), 5 done pulses, active never drops between frames.
//  3. PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, baud_div=8, send 0xA5 then 0x07 ->
//     parity bits 0 then 1; each frame 96 cycles, stop held high 16 cycles.
//  4. baud_div changes 16->8 during frame 1 -> frame 1 uses 16 throughout, frame 2 uses 8.
//  5. Assert rsnt_i_tx in the middle of DATA with 2 bytes queued -> line high immediately,
//     active=0, ready=1, no done pulse; after release the line stays idle (FIFO flushed).
//  6. baud_div=0, send 0xFF -> treated as 1 cycle/bit; 10-cycle frame, loopback through uart_rx recovers 0xFF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity helper.
// Used by uart_tx and uart_rx so both ends agree on framing.
package uart_pkg;

    // State encoding, kept as plain constants so uart_rx can reuse them
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } tx_state_t;

    // Parity over a zero-extended word; zero padding does not change the XOR
    function automatic logic calc_parity(
        input logic [31:0] i_data,
        input logic        i_odd
    );
        return (^i_data) ^ i_odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering bytes ahead of the UART serialiser.
// Head entry is presented combinationally on o_data.
module uart_tx_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_data,
    input  logic                       i_pop,
    output logic [DW-1:0]              o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage array: written on accepted pushes, no reset needed
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally; occupancy tracks push/pop balance
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialised LSB first with
// optional parity and one or two stop bits, frames sent back-to-back.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                    clk_i_tx,
    input  logic                    rsnt_i_tx,
    input  logic [DATA_WIDTH*2:0]   baud_div_i_tx,
    input  logic [DATA_WIDTH-1:0]   data_i_tx,
    input  logic                    valid_i_tx,
    output logic                    ready_o_tx,
    output logic                    data_o_serial_tx,
    output logic                    active_o_tx,
    output logic                    done_o_tx
);

    localparam int BW  = DATA_WIDTH * 2 + 1;
    localparam int BCW = $clog2(DATA_WIDTH) + 1;
    localparam int SCW = 2;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    tx_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic [BW-1:0]         r_div_q;
    logic [BW-1:0]         r_baud_cnt;
    logic [BCW-1:0]        r_bit_cnt;
    logic [SCW-1:0]        r_stop_cnt;
    logic                  r_serial;
    logic                  r_active;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_baud_last;
    logic                  w_bit_last;
    logic                  w_stop_last;
    logic                  w_frame_end;
    logic [BW-1:0]         w_div_new;
    logic                  w_par_new;

    assign ready_o_tx  = (w_count != CW'(FIFO_DEPTH));
    assign w_push      = valid_i_tx & ~w_full;
    assign w_baud_last = (r_baud_cnt == r_div_q - BW'(1));
    assign w_bit_last  = (r_bit_cnt == BCW'(DATA_WIDTH - 1));
    assign w_stop_last = (r_stop_cnt == SCW'(STOP_BITS - 1));
    assign w_frame_end = (r_state == ST_STOP) & w_baud_last & w_stop_last;
    assign w_pop       = ~w_empty & ((r_state == ST_IDLE) | w_frame_end);
    assign w_div_new   = (baud_div_i_tx == '0) ? BW'(1) : baud_div_i_tx;
    assign w_par_new   = calc_parity(32'(w_head), PARITY_ODD != 0);

    assign data_o_serial_tx = r_serial;
    assign active_o_tx      = r_active;
    assign done_o_tx        = r_done;

    uart_tx_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i_tx),
        .i_rst   (rsnt_i_tx),
        .i_push  (w_push),
        .i_data  (data_i_tx),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Frame sequencer with registered line, active and done outputs
    always_ff @(posedge clk_i_tx or posedge rsnt_i_tx) begin
        if (rsnt_i_tx) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_div_q    <= BW'(1);
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_serial   <= 1'b1;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_serial <= 1'b1;
                    r_active <= 1'b0;
                    if (w_pop) begin
                        r_shift    <= w_head;
                        r_par      <= w_par_new;
                        r_div_q    <= w_div_new;
                        r_baud_cnt <= '0;
                        r_serial   <= 1'b0;
                        r_active   <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_serial   <= r_shift[0];
                        r_shift    <= r_shift >> 1;
                        r_state    <= ST_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        if (w_bit_last) begin
                            if (PARITY_EN != 0) begin
                                r_serial <= r_par;
                                r_state  <= ST_PARITY;
                            end else begin
                                r_serial   <= 1'b1;
                                r_stop_cnt <= '0;
                                r_state    <= ST_STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                            r_serial  <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BW'(1);
                    end
                end
                ST_PARITY: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_serial   <= 1'b1;
                        r_stop_cnt <= '0;
                        r_state    <= ST_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        if (w_stop_last) begin
                            r_done <= 1'b1;
                            if (w_pop) begin
                                r_shift  <= w_head;
                                r_par    <= w_par_new;
                                r_div_q  <= w_div_new;
                                r_serial <= 1'b0;
                                r_state  <= ST_START;
                            end else begin
                                r_serial <= 1'b1;
                                r_active <= 1'b0;
                                r_state  <= ST_IDLE;
                            end
                        end else begin
                            r_stop_cnt <= r_stop_cnt + SCW'(1);
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BW'(1);
                    end
                end
                default: begin
                    r_serial <= 1'b1;
                    r_active <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: an 8N1 instance and an even-parity 2-stop instance
// share stimulus and are checked every cycle against a frame-level model.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] baud;
    logic [7:0]  data;
    logic        valid;
    logic [1:0]  ser, act, dn, rdy;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    uart_tx u_dut0 (
        .clk_i_tx         (clk),
        .rsnt_i_tx        (rst),
        .baud_div_i_tx    (baud),
        .data_i_tx        (data),
        .valid_i_tx       (valid),
        .ready_o_tx       (rdy[0]),
        .data_o_serial_tx (ser[0]),
        .active_o_tx      (act[0]),
        .done_o_tx        (dn[0])
    );

    uart_tx #(
        .PARITY_EN  (1),
        .PARITY_ODD (0),
        .STOP_BITS  (2)
    ) u_dut1 (
        .clk_i_tx         (clk),
        .rsnt_i_tx        (rst),
        .baud_div_i_tx    (baud),
        .data_i_tx        (data),
        .valid_i_tx       (valid),
        .ready_o_tx       (rdy[1]),
        .data_o_serial_tx (ser[1]),
        .active_o_tx      (act[1]),
        .done_o_tx        (dn[1])
    );

    task automatic chk(input string nm, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Whole frame as a bit vector: start, data LSB first, parity, stops
    function automatic logic [11:0] frame(input logic [7:0] b, input int d);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (d == 1) f[9] = ^b;
        return f;
    endfunction

    // Model: FIFO as ring array, transmitter as (frame, elapsed cycles)
    logic [7:0]  mmem [2][4];
    int          mcnt [2];
    int          mrd  [2];
    int          mwr  [2];
    bit          mbusy[2];
    bit          mdone[2];
    int          mt   [2];
    int          mlen [2];
    int          mdv  [2];
    logic [11:0] mfr  [2];
    int          m_pre;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                mcnt[d] = 0; mrd[d] = 0; mwr[d] = 0;
                mbusy[d] = 0; mdone[d] = 0; mt[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_pre    = mcnt[d];
                mdone[d] = 0;
                if (mbusy[d]) begin
                    mt[d] = mt[d] + 1;
                    if (mt[d] == mlen[d]) begin
                        mdone[d] = 1;
                        mbusy[d] = 0;
                    end
                end
                if (!mbusy[d] && mcnt[d] > 0) begin
                    mfr[d]  = frame(mmem[d][mrd[d]], d);
                    mrd[d]  = (mrd[d] + 1) % 4;
                    mcnt[d] = mcnt[d] - 1;
                    mdv[d]  = (baud == 0) ? 1 : int'(baud);
                    mlen[d] = (10 + 2 * d) * mdv[d];
                    mt[d]   = 0;
                    mbusy[d] = 1;
                end
                if (valid && m_pre < 4) begin
                    mmem[d][mwr[d]] = data;
                    mwr[d]  = (mwr[d] + 1) % 4;
                    mcnt[d] = mcnt[d] + 1;
                end
            end
        end
    end

    // Per-cycle compare and activity statistics
    int  actc [2] = '{0, 0};
    int  donec[2] = '{0, 0};
    int  risec[2] = '{0, 0};
    bit  pact [2] = '{0, 0};
    int  eline;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            eline = mbusy[d] ? int'(mfr[d][mt[d] / mdv[d]]) : 1;
            chk($sformatf("dut%0d line", d), int'(ser[d]), eline);
            chk($sformatf("dut%0d active", d), int'(act[d]), int'(mbusy[d]));
            chk($sformatf("dut%0d done", d), int'(dn[d]), int'(mdone[d]));
            chk($sformatf("dut%0d ready", d), int'(rdy[d]), int'(mcnt[d] < 4));
            if (act[d] === 1'b1) actc[d]++;
            if (dn[d] === 1'b1) donec[d]++;
            if (act[d] === 1'b1 && !pact[d]) risec[d]++;
            pact[d] = (act[d] === 1'b1);
        end
    end

    int ba[2], bd[2], br[2];

    task automatic snap();
        for (int d = 0; d < 2; d++) begin
            ba[d] = actc[d]; bd[d] = donec[d]; br[d] = risec[d];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push1(input logic [7:0] b);
        data  = b;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_low(input int d, input string nm);
        for (int i = 0; i < 400; i++) begin
            if (ser[d] == 1'b0) break;
            tick();
        end
        chk(nm, int'(ser[d]), 0);
    endtask

    logic [10:0] v;
    logic        p0, p1;
    int          low;
    bit          acc;

    initial begin
        rst = 1'b1; valid = 1'b0; data = '0; baud = 17'd16;
        tick(); tick();
        chk("reset line", int'(ser), 3);
        chk("reset active", int'(act), 0);
        chk("reset done", int'(dn), 0);
        chk("reset ready", int'(rdy), 3);
        rst = 1'b0;
        tick();

        // Single 0xA5 frame at 16 cycles per bit
        snap();
        push1(8'hA5);
        wait_low(0, "t1 start");
        v = '0;
        for (int k = 0; k < 10; k++) begin
            repeat (k == 0 ? 8 : 16) tick();
            v[k] = ser[0];
        end
        chk("t1 bits", int'(v[9:0]), 'h34A);
        repeat (250) tick();
        chk("t1 act0", actc[0] - ba[0], 160);
        chk("t1 done0", donec[0] - bd[0], 1);
        chk("t1 act1", actc[1] - ba[1], 192);
        chk("t1 done1", donec[1] - bd[1], 1);

        // Burst of six bytes, FIFO fills, frames stay contiguous
        baud = 17'd4;
        snap();
        low = 0;
        for (int i = 1; i <= 6; i++) begin
            data  = 8'(i);
            valid = 1'b1;
            for (int g = 0; g < 200; g++) begin
                acc = rdy[0];
                if (!rdy[0]) low++;
                tick();
                if (acc) break;
            end
        end
        valid = 1'b0;
        repeat (400) tick();
        chk("t2 ready dropped", int'(low > 0), 1);
        chk("t2 act0", actc[0] - ba[0], 240);
        chk("t2 done0", donec[0] - bd[0], 6);
        chk("t2 rise0", risec[0] - br[0], 1);

        // Even parity, two stops: 0xA5 then 0x07
        baud = 17'd8;
        snap();
        push1(8'hA5);
        push1(8'h07);
        wait_low(1, "t3 start");
        repeat (76) tick();
        p0 = ser[1];
        repeat (96) tick();
        p1 = ser[1];
        chk("t3 parity a5", int'(p0), 0);
        chk("t3 parity 07", int'(p1), 1);
        repeat (250) tick();
        chk("t3 act1", actc[1] - ba[1], 192);
        chk("t3 done1", donec[1] - bd[1], 2);
        chk("t3 rise1", risec[1] - br[1], 1);
        chk("t3 act0", actc[0] - ba[0], 160);

        // Divider change mid-frame only affects the next frame
        baud = 17'd16;
        snap();
        push1(8'h3C);
        push1(8'hC3);
        repeat (30) tick();
        baud = 17'd8;
        repeat (400) tick();
        chk("t4 act0", actc[0] - ba[0], 240);
        chk("t4 act1", actc[1] - ba[1], 288);
        chk("t4 done0", donec[0] - bd[0], 2);

        // Reset mid-data with bytes queued
        baud = 17'd16;
        push1(8'h11);
        push1(8'h22);
        push1(8'h33);
        repeat (40) tick();
        rst = 1'b1;
        #1;
        chk("t5 line", int'(ser), 3);
        chk("t5 active", int'(act), 0);
        chk("t5 ready", int'(rdy), 3);
        chk("t5 done", int'(dn), 0);
        tick(); tick(); tick();
        rst = 1'b0;
        snap();
        repeat (100) tick();
        chk("t5 idle act", actc[0] - ba[0] + actc[1] - ba[1], 0);
        chk("t5 idle done", donec[0] - bd[0] + donec[1] - bd[1], 0);

        // Divider 0 behaves as 1
        baud = 17'd0;
        snap();
        push1(8'hFF);
        wait_low(0, "t6 start");
        v[0] = ser[0];
        for (int k = 1; k < 11; k++) begin
            tick();
            v[k] = ser[0];
        end
        chk("t6 bits", int'(v), 'h7FE);
        repeat (20) tick();
        chk("t6 act0", actc[0] - ba[0], 10);
        chk("t6 act1", actc[1] - ba[1], 12);

        // Random traffic with a reset in the middle
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) baud = 17'($urandom_range(0, 6));
            valid = ($urandom_range(0, 4) == 0);
            data  = 8'($urandom);
            if (i == 2000) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end
        valid = 1'b0;
        repeat (200) tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
